// File: rtl/vga_bus_bridge_if.sv
// CPU-facing bus and vga_controller-facing strobe bundle for vga_bus_bridge.
// Handshake: a CPU request (cpu_sel with cpu_we or cpu_re) is taken on a clock edge where cpu_stall=0;
// while cpu_stall=1 the CPU holds the request unchanged. Read data is valid only while cpu_rvalid=1.
interface vga_bus_bridge_if #(
    parameter int AW = 22
);
    logic          cpu_sel;
    logic          cpu_we;
    logic          cpu_re;
    logic [AW-1:0] cpu_addr;
    logic [31:0]   cpu_wdata;
    logic [31:0]   cpu_rdata;
    logic          cpu_rvalid;
    logic          cpu_stall;
    logic [31:0]   vga_status;
    logic [31:0]   cursor_status;
    logic          we_text;
    logic          we_graph;
    logic          we_cursor;
    logic          we_reg;
    logic [12:0]   text_addr;
    logic [18:0]   graph_addr;
    logic [31:0]   data_out;
    logic          bad_addr;

    modport master (
        output cpu_sel, cpu_we, cpu_re, cpu_addr, cpu_wdata, vga_status, cursor_status,
        input  cpu_rdata, cpu_rvalid, cpu_stall, we_text, we_graph, we_cursor, we_reg,
               text_addr, graph_addr, data_out, bad_addr
    );

    modport slave (
        input  cpu_sel, cpu_we, cpu_re, cpu_addr, cpu_wdata, vga_status, cursor_status,
        output cpu_rdata, cpu_rvalid, cpu_stall, we_text, we_graph, we_cursor, we_reg,
               text_addr, graph_addr, data_out, bad_addr
    );
endinterface

// File: rtl/vga_bus_bridge.sv
// Decodes CPU writes into vga_controller strobes through an in-order FIFO, and serves
// status reads only after every earlier write has been strobed out.
module vga_bus_bridge #(
    parameter int DEPTH = 8,
    parameter int AW    = 22
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_test_hold,
    output logic [1:0]       o_dbg_state,
    vga_bus_bridge_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int EW = 2 + 19 + 32;

    localparam logic [1:0] T_TEXT   = 2'd0;
    localparam logic [1:0] T_GRAPH  = 2'd1;
    localparam logic [1:0] T_REG    = 2'd2;
    localparam logic [1:0] T_CURSOR = 2'd3;

    localparam logic [1:0] K_ZERO   = 2'd0;
    localparam logic [1:0] K_STATUS = 2'd1;
    localparam logic [1:0] K_CURSOR = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAIN = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    // ---------------- address decode ----------------
    logic [AW-1:0] w_off;
    logic          w_unused_addr;
    logic          w_is_graph;
    logic          w_is_text;
    logic          w_is_reg;
    logic          w_is_cursor;
    logic          w_mapped;
    logic [1:0]    w_type;
    logic [18:0]   w_addr;

    assign w_off         = bus.cpu_addr;
    assign w_unused_addr = ^w_off[1:0];
    assign w_is_graph    = w_off[21];
    assign w_is_text     = (w_off[21:15] == 7'd0);
    assign w_is_reg      = (w_off[21:2] == 20'h40000);
    assign w_is_cursor   = (w_off[21:2] == 20'h40001);
    assign w_mapped      = w_is_graph | w_is_text | w_is_reg | w_is_cursor;

    always_comb begin
        w_type = T_TEXT;
        w_addr = {6'd0, w_off[14:2]};
        if (w_is_graph) begin
            w_type = T_GRAPH;
            w_addr = w_off[20:2];
        end else if (w_is_reg) begin
            w_type = T_REG;
            w_addr = 19'd0;
        end else if (w_is_cursor) begin
            w_type = T_CURSOR;
            w_addr = 19'd0;
        end
    end

    // ---------------- write FIFO ----------------
    logic [PW:0]   r_wr_ptr;
    logic [PW:0]   r_rd_ptr;
    logic [EW-1:0] r_mem [DEPTH];
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic [EW-1:0] w_head;

    assign w_full  = (r_wr_ptr[PW] != r_rd_ptr[PW]) && (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    // A full FIFO rejects the push even when a pop frees a slot in the same cycle.
    assign w_push  = bus.cpu_sel & bus.cpu_we & w_mapped & ~w_full;
    assign w_pop   = ~w_empty & ~i_test_hold;
    assign w_head  = r_mem[r_rd_ptr[PW-1:0]];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[PW-1:0]] <= {w_type, w_addr, bus.cpu_wdata};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // ---------------- registered strobe outputs ----------------
    logic        r_we_text;
    logic        r_we_graph;
    logic        r_we_cursor;
    logic        r_we_reg;
    logic [12:0] r_text_addr;
    logic [18:0] r_graph_addr;
    logic [31:0] r_data_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we_text    <= 1'b0;
            r_we_graph   <= 1'b0;
            r_we_cursor  <= 1'b0;
            r_we_reg     <= 1'b0;
            r_text_addr  <= '0;
            r_graph_addr <= '0;
            r_data_out   <= '0;
        end else begin
            r_we_text    <= 1'b0;
            r_we_graph   <= 1'b0;
            r_we_cursor  <= 1'b0;
            r_we_reg     <= 1'b0;
            r_text_addr  <= '0;
            r_graph_addr <= '0;
            r_data_out   <= '0;
            if (w_pop) begin
                r_data_out <= w_head[31:0];
                case (w_head[EW-1:EW-2])
                    T_TEXT: begin
                        r_we_text   <= 1'b1;
                        r_text_addr <= w_head[44:32];
                    end
                    T_GRAPH: begin
                        r_we_graph   <= 1'b1;
                        r_graph_addr <= w_head[50:32];
                    end
                    T_REG:    r_we_reg    <= 1'b1;
                    default:  r_we_cursor <= 1'b1;
                endcase
            end
        end
    end

    assign bus.we_text    = r_we_text;
    assign bus.we_graph   = r_we_graph;
    assign bus.we_cursor  = r_we_cursor;
    assign bus.we_reg     = r_we_reg;
    assign bus.text_addr  = r_text_addr;
    assign bus.graph_addr = r_graph_addr;
    assign bus.data_out   = r_data_out;

    // ---------------- read FSM ----------------
    state_t      r_state;
    state_t      w_next;
    logic [1:0]  r_rd_kind;
    logic        w_rd_req;
    logic        w_quiet;
    logic        w_stall_rd;
    logic        w_rvalid;
    logic [31:0] w_rdata;
    logic        r_bad;

    assign w_rd_req = bus.cpu_sel & bus.cpu_re & ~bus.cpu_we;
    assign w_quiet  = w_empty & ~(r_we_text | r_we_graph | r_we_cursor | r_we_reg);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_rd_kind <= K_ZERO;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && w_rd_req) begin
                if (w_is_reg)         r_rd_kind <= K_STATUS;
                else if (w_is_cursor) r_rd_kind <= K_CURSOR;
                else                  r_rd_kind <= K_ZERO;
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        w_stall_rd = 1'b0;
        w_rvalid   = 1'b0;
        w_rdata    = 32'd0;
        case (r_state)
            S_IDLE: begin
                if (w_rd_req) begin
                    if (w_quiet) begin
                        w_next = S_RESP;
                    end else begin
                        w_next     = S_DRAIN;
                        w_stall_rd = 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                w_stall_rd = 1'b1;
                if (w_quiet) w_next = S_RESP;
            end
            S_RESP: begin
                w_rvalid = 1'b1;
                w_next   = S_IDLE;
                case (r_rd_kind)
                    K_STATUS: w_rdata = bus.vga_status;
                    K_CURSOR: w_rdata = bus.cursor_status;
                    default:  w_rdata = 32'd0;
                endcase
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bad <= 1'b0;
        end else if (bus.cpu_sel & (bus.cpu_we | bus.cpu_re) & ~w_mapped) begin
            r_bad <= 1'b1;
        end
    end

    assign bus.cpu_stall  = (bus.cpu_sel & bus.cpu_we & w_full) | w_stall_rd;
    assign bus.cpu_rvalid = w_rvalid;
    assign bus.cpu_rdata  = w_rdata;
    assign bus.bad_addr   = r_bad | w_unused_addr & 1'b0;
    assign o_dbg_state    = r_state;
endmodule

// File: tb/tb_vga_bus_bridge.sv
// Directed bench for vga_bus_bridge: drivers push expected strobes/read data into queues,
// a negedge monitor pops and compares whenever the bridge presents a strobe or read data.
module tb_vga_bus_bridge;
    logic       clk;
    logic       rst;
    logic       test_hold;
    logic [1:0] dbg_state;

    vga_bus_bridge_if #(.AW(22)) bus();

    vga_bus_bridge #(.DEPTH(8), .AW(22)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_test_hold (test_hold),
        .o_dbg_state (dbg_state),
        .bus         (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [31:0] VGA_STATUS    = 32'h5A5A_0001;
    localparam logic [31:0] CURSOR_STATUS = 32'hC0C0_1234;

    int n_checks = 0;
    int n_fail   = 0;

    logic [52:0] exp_q[$];
    logic [31:0] exp_rd_q[$];

    // burst table: offset, type, expected strobe address
    logic [21:0] tbl_off  [9];
    logic [1:0]  tbl_type [9];
    logic [18:0] tbl_addr [9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: actual=timeout/unexpected required=event", name);
    endtask

    // ---------------- drivers ----------------
    task automatic idle();
        bus.cpu_sel   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_re    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
    endtask

    task automatic wr(input logic [21:0] a, input logic [31:0] d, input logic [1:0] t,
                      input logic [18:0] ea, input bit push, output int waited);
        int n;
        bus.cpu_sel   = 1'b1;
        bus.cpu_we    = 1'b1;
        bus.cpu_re    = 1'b0;
        bus.cpu_addr  = a;
        bus.cpu_wdata = d;
        #1;
        n = 0;
        while (bus.cpu_stall && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 100) fail_now("wr_stall_timeout");
        waited = n;
        if (push) exp_q.push_back({t, ea, d});
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic rd(input logic [21:0] a, input logic [31:0] ed, output bit stalled0);
        int n;
        bus.cpu_sel  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_re   = 1'b1;
        bus.cpu_addr = a;
        exp_rd_q.push_back(ed);
        #1;
        stalled0 = bus.cpu_stall;
        n = 0;
        while (bus.cpu_stall && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 100) fail_now("rd_stall_timeout");
        @(posedge clk);
        #1;
        idle();
        n = 0;
        while (exp_rd_q.size() != 0 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 20) fail_now("rd_response_timeout");
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic [1:0]  m_type;
    logic [52:0] m_act;
    logic [52:0] m_exp;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.we_text | bus.we_graph | bus.we_cursor | bus.we_reg) begin
                check("strobe_onehot",
                      $countones({bus.we_text, bus.we_graph, bus.we_cursor, bus.we_reg}), 1);
                m_type = bus.we_graph ? 2'd1 : bus.we_reg ? 2'd2 : bus.we_cursor ? 2'd3 : 2'd0;
                m_act  = {m_type, bus.we_graph ? bus.graph_addr : {6'd0, bus.text_addr}, bus.data_out};
                check("unused_addr_zero",
                      bus.we_graph ? {6'd0, bus.text_addr} : bus.graph_addr, 0);
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_strobe");
                end else begin
                    m_exp = exp_q.pop_front();
                    check("strobe_entry", m_act, m_exp);
                end
            end
            if (bus.cpu_rvalid) begin
                check("rd_after_writes", exp_q.size(), 0);
                if (exp_rd_q.size() == 0) fail_now("unexpected_rvalid");
                else check("rdata", bus.cpu_rdata, exp_rd_q.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int  w;
        bit  st;

        tbl_off[0] = 22'h000100; tbl_type[0] = 2'd0; tbl_addr[0] = 19'h00040;
        tbl_off[1] = 22'h200000; tbl_type[1] = 2'd1; tbl_addr[1] = 19'h00000;
        tbl_off[2] = 22'h3FFFFC; tbl_type[2] = 2'd1; tbl_addr[2] = 19'h7FFFF;
        tbl_off[3] = 22'h007FFC; tbl_type[3] = 2'd0; tbl_addr[3] = 19'h01FFF;
        tbl_off[4] = 22'h100004; tbl_type[4] = 2'd3; tbl_addr[4] = 19'h00000;
        tbl_off[5] = 22'h100000; tbl_type[5] = 2'd2; tbl_addr[5] = 19'h00000;
        tbl_off[6] = 22'h000000; tbl_type[6] = 2'd0; tbl_addr[6] = 19'h00000;
        tbl_off[7] = 22'h2ABCD0; tbl_type[7] = 2'd1; tbl_addr[7] = 19'h2AF34;
        tbl_off[8] = 22'h000010; tbl_type[8] = 2'd0; tbl_addr[8] = 19'h00004;

        rst = 1'b1;
        test_hold = 1'b0;
        idle();
        bus.vga_status    = VGA_STATUS;
        bus.cursor_status = CURSOR_STATUS;
        repeat (3) @(negedge clk);

        check("rst_strobes", {bus.we_text, bus.we_graph, bus.we_cursor, bus.we_reg}, 0);
        check("rst_addrs", {bus.text_addr, bus.graph_addr}, 0);
        check("rst_data_out", bus.data_out, 0);
        check("rst_read", {bus.cpu_rvalid, bus.cpu_rdata}, 0);
        check("rst_stall_bad", {bus.cpu_stall, bus.bad_addr}, 0);
        check("rst_state", dbg_state, 0);

        rst = 1'b0;
        @(posedge clk);
        #1;

        // 1: single text write, strobe one cycle after acceptance
        wr(22'h000008, 32'h0000_0123, 2'd0, 19'd2, 1'b1, w);
        check("t1_no_stall", w, 0);
        @(posedge clk);
        #1;
        check("t1_we_text", bus.we_text, 1);
        check("t1_text_addr", bus.text_addr, 2);
        check("t1_data_out", bus.data_out, 32'h123);
        repeat (2) @(posedge clk);
        #1;

        // 2: graph then reg back-to-back, then a read with an idle FIFO
        wr(22'h200010, 32'hAAAA_0001, 2'd1, 19'd4, 1'b1, w);
        wr(22'h100000, 32'h0000_00F5, 2'd2, 19'd0, 1'b1, w);
        wait_drain("t2_drain");
        repeat (2) @(posedge clk);
        #1;
        rd(22'h100000, VGA_STATUS, st);
        check("t2_rd_no_stall", st, 0);

        // 3: fill the FIFO with draining held off, then overflow attempt
        test_hold = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wr(tbl_off[i], 32'hD000_0000 + i, tbl_type[i], tbl_addr[i], 1'b1, w);
            check("t3_fill_no_stall", w, 0);
        end
        bus.cpu_sel   = 1'b1;
        bus.cpu_we    = 1'b1;
        bus.cpu_addr  = tbl_off[8];
        bus.cpu_wdata = 32'hD000_0008;
        #1;
        check("t3_stall_full", bus.cpu_stall, 1);
        @(posedge clk);
        #1;
        check("t3_stall_held", bus.cpu_stall, 1);
        test_hold = 1'b0;
        wr(tbl_off[8], 32'hD000_0008, tbl_type[8], tbl_addr[8], 1'b1, w);
        check("t3_ninth_waited", w > 0, 1);
        wait_drain("t3_drain");

        // 4: read ordered after three queued writes
        wr(22'h000020, 32'h0000_0444, 2'd0, 19'd8, 1'b1, w);
        wr(22'h200008, 32'h0000_0555, 2'd1, 19'd2, 1'b1, w);
        wr(22'h100000, 32'h0000_0666, 2'd2, 19'd0, 1'b1, w);
        rd(22'h100004, CURSOR_STATUS, st);
        check("t4_rd_stalled", st, 1);

        // 5: unmapped write and read
        wr(22'h100008, 32'hDEAD_BEEF, 2'd0, 19'd0, 1'b0, w);
        repeat (3) @(posedge clk);
        #1;
        check("t5_bad_set", bus.bad_addr, 1);
        rd(22'h180000, 32'd0, st);
        check("t5_bad_sticky", bus.bad_addr, 1);

        // 6: reset with queued entries and one strobe in flight
        test_hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wr(tbl_off[i], 32'hE000_0000 + i, tbl_type[i], tbl_addr[i], 1'b1, w);
        end
        @(negedge clk);
        test_hold = 1'b0;
        @(posedge clk);
        #1;
        check("t6_strobe_before_rst", bus.we_text, 1);
        rst = 1'b1;
        #1;
        check("t6_rst_strobes", {bus.we_text, bus.we_graph, bus.we_cursor, bus.we_reg}, 0);
        check("t6_rst_bad_clear", bus.bad_addr, 0);
        check("t6_rst_state", dbg_state, 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        wr(22'h000008, 32'h0000_0777, 2'd0, 19'd2, 1'b1, w);
        check("t6_post_rst_no_stall", w, 0);
        wait_drain("t6_drain");

        check("end_rd_queue_empty", exp_rd_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
